ps2_frame_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_line_filter.sv | 40 ++++
 rtl/ps2_frame_rx.sv | 130 +++++++++++++
 tb/tb_ps2_frame_rx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared state type and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam int unsigned PS2_DATA_BITS = 8;

  // Prefix bytes interpreted downstream by ps2_Top.
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one asynchronous PS/2 line and debounces it: the output level
// follows the synced input only after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_line,
  output logic o_level
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // r_cnt counts consecutive synced samples that disagree with the output level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '1;
      r_cnt   <= '0;
      o_level <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      if (w_synced == o_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        o_level <= w_synced;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: conditions the raw lines, deserializes
// 11-bit frames and emits one checked scancode byte per frame.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [PS2_DATA_BITS-1:0] code,
  output logic                     code_valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int unsigned BIT_CNT_W = $clog2(PS2_DATA_BITS);
  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  ps2_rx_state_t            r_state;
  logic [BIT_CNT_W-1:0]     r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_par;
  logic [TO_W-1:0]          r_to_cnt;
  logic                     r_clk_prev;

  logic w_clk_filt;
  logic w_data_filt;
  logic w_fall;
  logic w_timeout;

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_line  (ps2_clk),
    .o_level (w_clk_filt)
  );

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_data_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_line  (ps2_data),
    .o_level (w_data_filt)
  );

  assign w_fall    = r_clk_prev & ~w_clk_filt;
  assign w_timeout = (r_state != IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Frame FSM; a timeout takes priority over a falling edge in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_to_cnt   <= '0;
      r_clk_prev <= 1'b1;
      code       <= '0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      r_clk_prev <= w_clk_filt;

      if (r_state == IDLE || w_timeout || w_fall) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (w_timeout) begin
        r_state   <= IDLE;
        busy      <= 1'b0;
        frame_err <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          IDLE: begin
            if (!w_data_filt) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
              busy      <= 1'b1;
            end
          end
          DATA: begin
            r_shift[r_bit_cnt] <= w_data_filt;
            r_bit_cnt          <= r_bit_cnt + BIT_CNT_W'(1);
            if (r_bit_cnt == BIT_CNT_W'(PS2_DATA_BITS - 1)) begin
              r_state <= PARITY;
            end
          end
          PARITY: begin
            r_par   <= w_data_filt;
            r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            busy    <= 1'b0;
            if (!w_data_filt) begin
              frame_err <= 1'b1;
            end else if (!(^{r_shift, r_par})) begin
              parity_err <= 1'b1;
            end else begin
              code       <= r_shift;
              code_valid <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed and random PS/2 frames
// compared every cycle against a window-filter / bit-list protocol model.
module tb_ps2_frame_rx;

  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned FILTER_LEN     = 4;
  // Shortened so the timeout path is reachable with compressed PS/2 bit periods.
  localparam int unsigned TIMEOUT_CYCLES = 400;
  localparam int unsigned HIST           = SYNC_STAGES + FILTER_LEN;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Behavioural model state
  logic [HIST-1:0] hc = '1;
  logic [HIST-1:0] hd = '1;
  logic            fc = 1'b1, fc_prev = 1'b1, fd = 1'b1;
  logic            in_frame = 1'b0;
  logic            bits[$];
  int unsigned     since = 0;
  logic [7:0]      m_code = 8'h00;
  logic            m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;

  function automatic logic settle(input logic [HIST-1:0] h, input logic cur);
    logic [FILTER_LEN-1:0] w;
    w = h[HIST-1:SYNC_STAGES];
    if (&w) return 1'b1;
    if (~|w) return 1'b0;
    return cur;
  endfunction

  always @(posedge clk) begin
    logic fall, dval, fc_new, fd_new, p;
    cyc++;
    if (!reset_n) begin
      hc = '1; hd = '1;
      fc = 1'b1; fc_prev = 1'b1; fd = 1'b1;
      in_frame = 1'b0; since = 0; bits.delete();
      m_code = 8'h00; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
    end else begin
      hc = {hc[HIST-2:0], ps2_clk};
      hd = {hd[HIST-2:0], ps2_data};
      fall = fc_prev & ~fc;
      dval = fd;
      fc_new = settle(hc, fc);
      fd_new = settle(hd, fd);
      m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
      if (in_frame) begin
        if (since == TIMEOUT_CYCLES - 1) begin
          in_frame = 1'b0; m_ferr = 1'b1; since = 0; bits.delete();
        end else if (fall) begin
          since = 0;
          bits.push_back(dval);
          if (bits.size() == 11) begin
            p = 1'b0;
            for (int i = 1; i <= 9; i++) p = p ^ bits[i];
            if (!bits[10]) m_ferr = 1'b1;
            else if (!p) m_perr = 1'b1;
            else begin
              for (int i = 0; i < 8; i++) m_code[i] = bits[i+1];
              m_valid = 1'b1;
            end
            in_frame = 1'b0;
            bits.delete();
          end
        end else begin
          since++;
        end
      end else begin
        since = 0;
        if (fall && !dval) begin
          in_frame = 1'b1;
          bits.delete();
          bits.push_back(1'b0);
        end
      end
      fc_prev = fc; fc = fc_new; fd = fd_new;
    end
  end

  // Pulse counters and timestamps observed from the DUT
  int unsigned n_valid = 0, n_perr = 0, n_ferr = 0, n_busy = 0;
  int unsigned fall_cyc = 0, ferr_cyc = 0;
  int unsigned v0 = 0, p0 = 0, f0 = 0, b0 = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      check("outputs", {4'h0, code, code_valid, parity_err, frame_err, busy},
            {4'h0, m_code, m_valid, m_perr, m_ferr, in_frame});
      check("exclusive", 16'($countones({code_valid, parity_err, frame_err}) <= 1), 16'd1);
      if (code_valid) n_valid++;
      if (parity_err) n_perr++;
      if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
      if (busy) n_busy++;
    end
    #1;
  endtask

  task automatic snap();
    v0 = n_valid; p0 = n_perr; f0 = n_ferr; b0 = n_busy;
  endtask

  task automatic expect_counts(input string name, input int unsigned dv, input int unsigned dp,
                               input int unsigned df);
    check(name, {16'(n_valid - v0)}, 16'(dv));
    check(name, {16'(n_perr - p0)}, 16'(dp));
    check(name, {16'(n_ferr - f0)}, 16'(df));
  endtask

  task automatic send_bit(input logic b, input int unsigned half);
    ps2_data = b;
    tick(half);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    tick(half);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int unsigned half, input int unsigned nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < int'(nbits); i++) send_bit(f[i], half);
    ps2_data = 1'b1;
    tick(half);
  endtask

  initial begin
    int unsigned variant, half, nb;
    logic [7:0]  d;

    tick(4);
    check("reset_outs", {4'h0, code, code_valid, parity_err, frame_err, busy}, 16'h0000);
    reset_n = 1'b1;
    tick(10);

    // Single good frame 0x1C
    snap();
    send_frame(8'h1C, 1'b0, 1'b0, 40, 11);
    tick(20);
    expect_counts("f1c_counts", 1, 0, 0);
    check("f1c_code", {8'h0, code}, 16'h001C);
    check("f1c_model", {8'h0, m_code}, 16'h001C);
    check("f1c_busy", {15'h0, busy}, 16'h0000);

    // Back-to-back 0xF0 then 0x1C
    snap();
    send_frame(8'hF0, 1'b0, 1'b0, 30, 11);
    check("bb_code_f0", {8'h0, code}, 16'h00F0);
    send_frame(8'h1C, 1'b0, 1'b0, 30, 11);
    tick(20);
    expect_counts("bb_counts", 2, 0, 0);
    check("bb_code_1c", {8'h0, code}, 16'h001C);

    // Bad parity, then bad stop: code must hold
    snap();
    send_frame(8'h1C, 1'b1, 1'b0, 30, 11);
    tick(20);
    expect_counts("par_counts", 0, 1, 0);
    check("par_code", {8'h0, code}, 16'h001C);
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 30, 11);
    tick(20);
    expect_counts("stop_counts", 0, 0, 1);
    check("stop_code", {8'h0, code}, 16'h001C);

    // Start + 4 data bits, then silence until timeout
    snap();
    send_frame(8'h29, 1'b0, 1'b0, 30, 5);
    tick(TIMEOUT_CYCLES + 20);
    expect_counts("to_counts", 0, 0, 1);
    check("to_latency", 16'(ferr_cyc - fall_cyc), 16'(TIMEOUT_CYCLES + 7));
    check("to_busy", {15'h0, busy}, 16'h0000);
    snap();
    send_frame(8'h29, 1'b0, 1'b0, 30, 11);
    tick(20);
    expect_counts("after_to_counts", 1, 0, 0);
    check("after_to_code", {8'h0, code}, 16'h0029);

    // 3-cycle clock glitch with data low: must be ignored
    ps2_data = 1'b0;
    tick(8);
    snap();
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(15);
    ps2_data = 1'b1;
    tick(10);
    check("glitch3_busy", 16'(n_busy - b0), 16'd0);
    expect_counts("glitch3_counts", 0, 0, 0);

    // 4-cycle pulse is the shortest accepted edge: starts a frame that times out
    ps2_data = 1'b0;
    tick(8);
    snap();
    ps2_clk = 1'b0;
    tick(4);
    ps2_clk = 1'b1;
    tick(20);
    check("pulse4_busy", {15'h0, (n_busy != b0)}, 16'h0001);
    ps2_data = 1'b1;
    tick(TIMEOUT_CYCLES + 20);
    expect_counts("pulse4_counts", 0, 0, 1);

    // Reset mid-frame, then a clean frame
    send_frame(8'h1C, 1'b0, 1'b0, 30, 6);
    reset_n = 1'b0;
    tick(3);
    check("midrst_outs", {4'h0, code, code_valid, parity_err, frame_err, busy}, 16'h0000);
    reset_n = 1'b1;
    tick(10);
    snap();
    send_frame(8'h1C, 1'b0, 1'b0, 30, 11);
    tick(20);
    expect_counts("midrst_counts", 1, 0, 0);
    check("midrst_code", {8'h0, code}, 16'h001C);

    // Randomized frames
    for (int k = 0; k < 24; k++) begin
      d       = 8'($urandom);
      half    = $urandom_range(8, 30);
      variant = $urandom_range(0, 9);
      snap();
      case (variant)
        0: begin
          send_frame(d, 1'b1, 1'b0, half, 11);
          tick(20);
          expect_counts("rnd_par", 0, 1, 0);
        end
        1: begin
          send_frame(d, 1'b0, 1'b1, half, 11);
          tick(20);
          expect_counts("rnd_stop", 0, 0, 1);
        end
        2: begin
          nb = $urandom_range(1, 10);
          send_frame(d, 1'b0, 1'b0, half, nb);
          tick(TIMEOUT_CYCLES + 20);
          expect_counts("rnd_trunc", 0, 0, 1);
        end
        default: begin
          send_frame(d, 1'b0, 1'b0, half, 11);
          tick(20);
          expect_counts("rnd_good", 1, 0, 0);
          check("rnd_code", {8'h0, code}, {8'h0, d});
        end
      endcase
      tick($urandom_range(2, 30));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
